// File: rtl/spi_cfg_seq.sv
// 3-wire SPI configuration sequencer: walks one register LUT per chip select,
// with optional readback/compare/retry per entry and sticky done/error reporting.
module spi_cfg_seq #(
    parameter int NUM_DEV   = 3,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int LUT_AW    = 10,
    parameter int CLK_DIV   = 5,
    parameter int START_DLY = 1000,
    parameter int CS_GAP    = 4,
    parameter int MAX_RETRY = 3,
    localparam int DEV_W    = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1,
    localparam int ENT_W    = 2 + ADDR_W + DATA_W
) (
    input  logic                clk_50m,
    input  logic                rst,
    input  logic                start,
    output logic [DEV_W-1:0]    dev_sel,
    output logic [LUT_AW-1:0]   lut_index,
    input  logic [ENT_W-1:0]    lut_data,
    output logic                spi_sclk,
    output logic                spi_sdio_o,
    output logic                spi_sdio_oe,
    input  logic                spi_sdio_i,
    output logic [NUM_DEV-1:0]  spi_cs_n,
    output logic                busy,
    output logic                done_flag,
    output logic                err_flag,
    output logic [DEV_W-1:0]    err_dev,
    output logic [ADDR_W-1:0]   err_addr
);

    localparam int INSTR_LEN = 3 + ADDR_W;
    localparam int FRAME_LEN = INSTR_LEN + DATA_W;
    localparam int LAST_HALF = 2 * FRAME_LEN + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_FETCH, S_SHIFT, S_CHECK, S_GAP, S_DONE, S_ABORT
    } state_t;

    state_t                r_state, w_state_next;
    logic [31:0]           r_cnt, r_half, r_try;
    logic [DEV_W-1:0]      r_dev, r_err_dev;
    logic [LUT_AW-1:0]     r_idx;
    logic [NUM_DEV-1:0]    r_cs_n;
    logic                  r_sclk, r_sdo, r_oe, r_rd, r_repeat, r_err;
    logic [FRAME_LEN-1:0]  r_sh;
    logic [ADDR_W-1:0]     r_addr, r_err_addr;
    logic [DATA_W-1:0]     r_data, r_rdata;

    logic                  w_abort, w_end, w_ent_rd, w_last_dev, w_last_idx;
    logic                  w_fetch_ok, w_tick, w_frame_end, w_gap_end, w_match;
    logic                  w_busy, w_done;
    logic [ADDR_W-1:0]     w_ent_addr;
    logic [DATA_W-1:0]     w_ent_data;
    logic [FRAME_LEN-1:0]  w_frame;
    logic [31:0]           w_half_next;

    assign w_abort     = (r_state inside {S_WAIT, S_FETCH, S_SHIFT, S_CHECK, S_GAP}) && !start;
    assign w_end       = lut_data[ENT_W-1];
    assign w_ent_rd    = lut_data[ENT_W-2];
    assign w_ent_addr  = lut_data[DATA_W +: ADDR_W];
    assign w_ent_data  = lut_data[DATA_W-1:0];
    assign w_frame     = {w_ent_rd, 2'b00, w_ent_addr, w_ent_data};
    assign w_last_dev  = (r_dev == DEV_W'(NUM_DEV - 1));
    assign w_last_idx  = (r_idx == {LUT_AW{1'b1}});
    // lut_data reflects the current index two cycles after it changes
    assign w_fetch_ok  = (r_cnt == 32'd1);
    assign w_tick      = (r_cnt == 32'(CLK_DIV - 1));
    assign w_frame_end = w_tick && (r_half == 32'(LAST_HALF));
    assign w_gap_end   = (r_cnt == 32'(CS_GAP - 1));
    assign w_match     = (r_rdata == r_data);
    assign w_half_next = r_half + 32'd1;

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        if (w_abort) begin
            w_state_next = S_ABORT;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_next = S_WAIT;
                S_WAIT:  if (r_cnt == 32'(START_DLY - 1)) w_state_next = S_FETCH;
                S_FETCH: begin
                    if (w_fetch_ok) begin
                        if (!w_end)
                            w_state_next = S_SHIFT;
                        else if (w_last_dev)
                            w_state_next = S_DONE;
                    end
                end
                S_SHIFT: if (w_frame_end) w_state_next = r_rd ? S_CHECK : S_GAP;
                S_CHECK: w_state_next = S_GAP;
                S_GAP: begin
                    if (w_gap_end)
                        w_state_next = (!r_repeat && w_last_idx && w_last_dev) ? S_DONE : S_FETCH;
                end
                S_DONE:  w_state_next = S_DONE;
                S_ABORT: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
        w_busy = (r_state inside {S_WAIT, S_FETCH, S_SHIFT, S_CHECK, S_GAP});
        w_done = (r_state == S_DONE);
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_half     <= '0;
            r_try      <= '0;
            r_dev      <= '0;
            r_idx      <= '0;
            r_cs_n     <= '1;
            r_sclk     <= 1'b0;
            r_sdo      <= 1'b0;
            r_oe       <= 1'b0;
            r_rd       <= 1'b0;
            r_repeat   <= 1'b0;
            r_err      <= 1'b0;
            r_err_dev  <= '0;
            r_err_addr <= '0;
            r_sh       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rdata    <= '0;
        end else if (w_abort) begin
            r_cs_n   <= '1;
            r_sclk   <= 1'b0;
            r_oe     <= 1'b0;
            r_sdo    <= 1'b0;
            r_dev    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_half   <= '0;
            r_try    <= '0;
            r_repeat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dev    <= '0;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_try    <= '0;
                        r_repeat <= 1'b0;
                    end
                end
                S_WAIT: r_cnt <= (r_cnt == 32'(START_DLY - 1)) ? 32'd0 : r_cnt + 32'd1;
                S_FETCH: begin
                    if (w_fetch_ok) begin
                        r_cnt <= '0;
                        if (w_end) begin
                            if (!w_last_dev) begin
                                r_dev <= r_dev + 1'b1;
                                r_idx <= '0;
                            end
                        end else begin
                            r_rd   <= w_ent_rd;
                            r_addr <= w_ent_addr;
                            r_data <= w_ent_data;
                            r_sh   <= {w_frame[FRAME_LEN-2:0], 1'b0};
                            r_sdo  <= w_frame[FRAME_LEN-1];
                            r_cs_n <= ~(NUM_DEV'(1) << r_dev);
                            r_oe   <= 1'b1;
                            r_sclk <= 1'b0;
                            r_half <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_SHIFT: begin
                    if (w_frame_end) begin
                        r_cs_n   <= '1;
                        r_oe     <= 1'b1;
                        r_sclk   <= 1'b0;
                        r_cnt    <= '0;
                        r_repeat <= 1'b0;
                    end else if (w_tick) begin
                        r_cnt  <= '0;
                        r_half <= w_half_next;
                        // odd half-periods start with a rise, even ones with a fall
                        if (w_half_next < 32'(LAST_HALF)) begin
                            if (w_half_next[0]) begin
                                r_sclk <= 1'b1;
                                if (w_half_next > 32'(2 * INSTR_LEN))
                                    r_rdata <= {r_rdata[DATA_W-2:0], spi_sdio_i};
                            end else begin
                                r_sclk <= 1'b0;
                                r_sdo  <= r_sh[FRAME_LEN-1];
                                r_sh   <= {r_sh[FRAME_LEN-2:0], 1'b0};
                                if (r_rd && (w_half_next == 32'(2 * INSTR_LEN)))
                                    r_oe <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        r_try    <= '0;
                        r_repeat <= 1'b0;
                    end else if (r_try < 32'(MAX_RETRY)) begin
                        r_try    <= r_try + 32'd1;
                        r_repeat <= 1'b1;
                    end else begin
                        r_try    <= '0;
                        r_repeat <= 1'b0;
                        if (!r_err) begin
                            r_err_dev  <= r_dev;
                            r_err_addr <= r_addr;
                        end
                        r_err <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        // the last LUT slot implicitly ends the table; the index never wraps
                        if (!r_repeat) begin
                            if (w_last_idx) begin
                                if (!w_last_dev) begin
                                    r_dev <= r_dev + 1'b1;
                                    r_idx <= '0;
                                end
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dev_sel     = r_dev;
    assign lut_index   = r_idx;
    assign spi_sclk    = r_sclk;
    assign spi_sdio_o  = r_sdo;
    assign spi_sdio_oe = r_oe;
    assign spi_cs_n    = r_cs_n;
    assign busy        = w_busy;
    assign done_flag   = w_done;
    assign err_flag    = r_err;
    assign err_dev     = r_err_dev;
    assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Scoreboard bench for spi_cfg_seq: a table-level model predicts every frame,
// a bus monitor with an embedded SPI device model checks what appears on the wire.
module tb_spi_cfg_seq;
    localparam int NUM_DEV   = 3;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 8;
    localparam int LUT_AW    = 3;
    localparam int CLK_DIV   = 5;
    localparam int START_DLY = 20;
    localparam int CS_GAP    = 4;
    localparam int MAX_RETRY = 3;
    localparam int INSTR_LEN = 3 + ADDR_W;
    localparam int FRAME_LEN = INSTR_LEN + DATA_W;
    localparam int DEPTH     = 1 << LUT_AW;
    localparam int FRAME_CYC = 2 * CLK_DIV * (FRAME_LEN + 1);
    localparam int FETCH_CYC = 2;
    localparam int BUDGET    = 20000;

    logic                clk_50m = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          dev_sel;
    logic [LUT_AW-1:0]   lut_index;
    logic [22:0]         lut_data;
    logic                spi_sclk, spi_sdio_o, spi_sdio_oe;
    logic                spi_sdio_i = 1'b0;
    logic [NUM_DEV-1:0]  spi_cs_n;
    logic                busy, done_flag, err_flag;
    logic [1:0]          err_dev;
    logic [ADDR_W-1:0]   err_addr;

    spi_cfg_seq #(
        .NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LUT_AW(LUT_AW),
        .CLK_DIV(CLK_DIV), .START_DLY(START_DLY), .CS_GAP(CS_GAP), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_50m(clk_50m), .rst(rst), .start(start), .dev_sel(dev_sel),
        .lut_index(lut_index), .lut_data(lut_data), .spi_sclk(spi_sclk),
        .spi_sdio_o(spi_sdio_o), .spi_sdio_oe(spi_sdio_oe), .spi_sdio_i(spi_sdio_i),
        .spi_cs_n(spi_cs_n), .busy(busy), .done_flag(done_flag), .err_flag(err_flag),
        .err_dev(err_dev), .err_addr(err_addr)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        int         dev;
        logic [15:0] instr;
        logic [7:0]  data;
        bit          rd;
    } frame_t;

    logic [22:0] lut_mem [NUM_DEV][DEPTH];
    int          fails_cfg [int];
    int          fails_left [int];
    logic [7:0]  dev_mem [int];
    frame_t      exp_q [$];

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  frames_seen = 0;
    int  mon_rises = 0;
    int  last_rise_cyc = 0;
    bit  discard = 0;
    bit  exp_err;
    int  exp_err_dev, exp_err_addr;

    // registered LUT ROM
    always @(posedge clk_50m) lut_data <= lut_mem[dev_sel][lut_index];
    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_tables();
        for (int d = 0; d < NUM_DEV; d++)
            for (int i = 0; i < DEPTH; i++)
                lut_mem[d][i] = {1'b1, 1'b0, 13'd0, 8'd0};
        fails_cfg.delete();
        dev_mem.delete();
    endtask

    task automatic add_entry(int d, int i, bit rd, int addr, int data, int nfail);
        int key;
        key = d * 8192 + addr;
        lut_mem[d][i] = {1'b0, rd, 13'(addr), 8'(data)};
        dev_mem[key] = 8'(data);
        if (rd) fails_cfg[key] = nfail;
    endtask

    // Reference: every non-END entry of each table in order, reads repeated
    // (failures+1) times capped at 1+MAX_RETRY, the first exhausted read recorded.
    task automatic build_expected();
        frame_t f;
        logic [22:0] e;
        int key, nfr, nf;
        exp_q.delete();
        exp_err = 0; exp_err_dev = 0; exp_err_addr = 0;
        fails_left = fails_cfg;
        for (int d = 0; d < NUM_DEV; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                e = lut_mem[d][i];
                if (e[22]) break;
                key = d * 8192 + int'(e[20:8]);
                nf = (e[21] && fails_cfg.exists(key)) ? fails_cfg[key] : 0;
                nfr = (nf > MAX_RETRY) ? MAX_RETRY + 1 : nf + 1;
                f.dev = d; f.instr = {e[21], 2'b00, e[20:8]}; f.data = e[7:0]; f.rd = e[21];
                for (int k = 0; k < nfr; k++) exp_q.push_back(f);
                if (nf > MAX_RETRY && !exp_err) begin
                    exp_err = 1; exp_err_dev = d; exp_err_addr = int'(e[20:8]);
                end
            end
        end
    endtask

    // Bus monitor + SPI device model
    initial begin : monitor
        bit          in_frame, prev_sclk, rd_frame, oe_ok;
        int          fdev, low, rises, falls, key;
        logic [15:0] instr;
        logic [7:0]  wdata, resp;
        frame_t      e;
        in_frame = 0; prev_sclk = 0; rd_frame = 0; oe_ok = 1;
        fdev = 0; low = 0; rises = 0; falls = 0; key = 0;
        instr = '0; wdata = '0; resp = '0;
        forever begin
            @(negedge clk_50m);
            if (spi_cs_n != '1) begin
                check("cs_onehot", 32'($countones(~spi_cs_n)), 32'd1);
                if (!in_frame) begin
                    in_frame = 1; frames_seen++; mon_rises = 0;
                    low = 0; rises = 0; falls = 0; instr = '0; wdata = '0;
                    oe_ok = 1; rd_frame = 0; spi_sdio_i = 1'b0;
                    for (int b = 0; b < NUM_DEV; b++) if (!spi_cs_n[b]) fdev = b;
                end
                low++;
                if (spi_sclk && !prev_sclk) begin
                    if (rises < INSTR_LEN) begin
                        instr = {instr[14:0], spi_sdio_o};
                        if (!spi_sdio_oe) oe_ok = 0;
                    end else if (rd_frame) begin
                        if (spi_sdio_oe) oe_ok = 0;
                    end else begin
                        wdata = {wdata[6:0], spi_sdio_o};
                        if (!spi_sdio_oe) oe_ok = 0;
                    end
                    rises++; mon_rises = rises;
                    if (rises == INSTR_LEN) begin
                        rd_frame = instr[15];
                        key = fdev * 8192 + int'(instr[12:0]);
                        resp = dev_mem.exists(key) ? dev_mem[key] : 8'h00;
                        if (rd_frame && fails_left.exists(key) && fails_left[key] > 0) begin
                            fails_left[key] = fails_left[key] - 1;
                            resp = (resp != 8'h00) ? 8'h00 : 8'hFF;
                        end
                    end
                end
                if (!spi_sclk && prev_sclk) begin
                    falls++;
                    if (rd_frame && falls >= INSTR_LEN && falls < FRAME_LEN)
                        spi_sdio_i = resp[7 - (falls - INSTR_LEN)];
                end
            end else if (in_frame) begin
                in_frame = 0; spi_sdio_i = 1'b0;
                if (discard) begin
                    discard = 0;
                    $display("[TB] partial frame dropped dev=%0d rises=%0d", fdev, rises);
                end else if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame: got dev=%0d instr=0x%04h, expected no frame", fdev, instr);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] frame dev=%0d instr=0x%04h data=0x%02h rd=%0d rises=%0d low=%0d",
                             fdev, instr, wdata, rd_frame, rises, low);
                    check("frame_dev", 32'(fdev), 32'(e.dev));
                    check("frame_instr", 32'(instr), 32'(e.instr));
                    check("frame_rises", 32'(rises), 32'(FRAME_LEN));
                    check("frame_cs_low", 32'(low), 32'(FRAME_CYC));
                    check("frame_oe", 32'(oe_ok), 32'd1);
                    check("oe_after_frame", 32'(spi_sdio_oe), 32'd1);
                    if (!e.rd) check("frame_wdata", 32'(wdata), 32'(e.data));
                    last_rise_cyc = cyc;
                end
            end
            prev_sclk = spi_sclk;
        end
    end

    task automatic check_reset_vals(string tag);
        check({tag, "_sclk"}, 32'(spi_sclk), 32'd0);
        check({tag, "_cs_n"}, 32'(spi_cs_n), 32'h7);
        check({tag, "_oe"}, 32'(spi_sdio_oe), 32'd0);
        check({tag, "_sdo"}, 32'(spi_sdio_o), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done_flag), 32'd0);
        check({tag, "_err"}, 32'(err_flag), 32'd0);
        check({tag, "_dev_sel"}, 32'(dev_sel), 32'd0);
        check({tag, "_lut_index"}, 32'(lut_index), 32'd0);
        check({tag, "_err_dev"}, 32'(err_dev), 32'd0);
        check({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);
    endtask

    task automatic wait_done(output int done_cyc);
        int n;
        n = 0;
        while (!done_flag && n < BUDGET) begin
            @(negedge clk_50m);
            n++;
        end
        done_cyc = cyc;
        check("done_reached", 32'(done_flag), 32'd1);
    endtask

    task automatic wait_frame(int target, int nrises);
        int n;
        n = 0;
        while (!(frames_seen >= target && mon_rises >= nrises) && n < BUDGET) begin
            @(negedge clk_50m);
            n++;
        end
        check("frame_reached", 32'(frames_seen >= target && mon_rises >= nrises), 32'd1);
    endtask

    task automatic finish_scenario(string name);
        int dc;
        wait_done(dc);
        repeat (2) @(negedge clk_50m);
        check({name, "_frames_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_err_flag"}, 32'(err_flag), 32'(exp_err));
        check({name, "_err_dev"}, 32'(err_dev), 32'(exp_err_dev));
        check({name, "_err_addr"}, 32'(err_addr), 32'(exp_err_addr));
        check({name, "_busy"}, 32'(busy), 32'd0);
        $display("[TB] scenario %s complete", name);
        start = 1'b0;
    endtask

    task automatic run_plain(string name);
        build_expected();
        do_reset();
        start = 1'b1;
        finish_scenario(name);
    endtask

    initial begin
        int dc, base, nent, rd, nf;
        clear_tables();
        do_reset();
        check_reset_vals("reset");

        // single write, then done latency: gap plus one fetch per remaining table lookup
        clear_tables();
        add_entry(0, 0, 0, 13'h000, 8'h3C, 0);
        build_expected();
        do_reset();
        start = 1'b1;
        wait_done(dc);
        check("done_latency", 32'(dc - last_rise_cyc), 32'(CS_GAP + FETCH_CYC * NUM_DEV));
        finish_scenario("write1");

        clear_tables();
        add_entry(0, 0, 1, 13'h0FF, 8'hA5, 0);
        run_plain("read_ok");

        clear_tables();
        add_entry(0, 0, 1, 13'h0FF, 8'hA5, 100);
        add_entry(0, 1, 0, 13'h001, 8'h11, 0);
        run_plain("read_fail");

        clear_tables();
        add_entry(0, 0, 0, 13'h010, 8'h01, 0);
        add_entry(0, 1, 0, 13'h011, 8'h02, 0);
        add_entry(2, 0, 1, 13'h123, 8'h5A, 2);
        run_plain("tables_2_0_1");

        // full table with no END on device 1: last slot is sent, no wrap
        clear_tables();
        add_entry(0, 0, 0, 13'h1F0, 8'h77, 0);
        for (int i = 0; i < DEPTH; i++)
            add_entry(1, i, (i == 3), (i << 4) | 13'h003, $urandom_range(1, 255), (i == 3) ? 1 : 0);
        run_plain("max_index");

        // abort at bit 10 of frame 2, restart from device 0 index 0
        clear_tables();
        add_entry(0, 0, 0, 13'h020, 8'hC1, 0);
        add_entry(0, 1, 0, 13'h021, 8'hC2, 0);
        add_entry(0, 2, 0, 13'h022, 8'hC3, 0);
        add_entry(2, 0, 0, 13'h030, 8'hD4, 0);
        build_expected();
        do_reset();
        base = frames_seen;
        start = 1'b1;
        wait_frame(base + 2, 10);
        discard = 1;
        start = 1'b0;
        @(posedge clk_50m);
        #1;
        check("abort_cs_n", 32'(spi_cs_n), 32'h7);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        check("abort_oe", 32'(spi_sdio_oe), 32'd0);
        check("abort_done", 32'(done_flag), 32'd0);
        repeat (5) @(negedge clk_50m);
        build_expected();
        start = 1'b1;
        finish_scenario("abort_restart");

        // asynchronous reset in the middle of a frame, start held high
        clear_tables();
        add_entry(0, 0, 0, 13'h040, 8'h99, 0);
        add_entry(1, 0, 1, 13'h041, 8'h66, 0);
        build_expected();
        do_reset();
        base = frames_seen;
        start = 1'b1;
        wait_frame(base + 1, 5);
        discard = 1;
        #3 rst = 1'b1;
        #1 check_reset_vals("midrst");
        repeat (2) @(negedge clk_50m);
        build_expected();
        rst = 1'b0;
        finish_scenario("rst_restart");

        for (int s = 0; s < 4; s++) begin
            clear_tables();
            for (int d = 0; d < NUM_DEV; d++) begin
                nent = $urandom_range(0, 2);
                for (int i = 0; i < nent; i++) begin
                    rd = $urandom_range(0, 1);
                    nf = rd ? $urandom_range(0, MAX_RETRY + 1) : 0;
                    add_entry(d, i, rd[0], ($urandom_range(0, 1023) << 3) | i,
                              $urandom_range(0, 255), nf);
                end
            end
            run_plain($sformatf("random%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
